// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: shared types and constants for the ROM port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rom_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    ACK   = 2'd3
  } arb_state_e;

  localparam int         ROM_WORD_W = 32;
  localparam logic [1:0] LANE_LAST  = 2'd3;

endpackage

// File: rtl/rom_rr_picker.sv
// rom_rr_picker: combinational pick of the next read requester, searching upward from ptr+1 with wrap.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when a pick is consumed.
// Ports: req (request vector), ptr (last granted index) -> gnt (one-hot), gnt_idx (binary), vld (any grant).
// Config: ROM_ARB_FIXED_PRIO_EN makes requester 0 win outright whenever it requests.
module rom_rr_picker
  import rom_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   gnt_idx,
  output logic               vld
);

  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    vld     = 1'b0;
`ifdef ROM_ARB_FIXED_PRIO_EN
    // Requester 0 pre-empts the rotation; the remaining search only runs when it is idle.
    if (req[0]) begin
      gnt[0] = 1'b1;
      vld    = 1'b1;
    end
`endif
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(ptr) + off) % NUM_REQ;
      if (!vld && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = PTR_W'(idx);
        vld      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares one 32-bit memory port between NUM_REQ round-robin readers and a byte-packed download writer.
// Latency: rd_req seen in IDLE cycle t -> mem_req at t+1; mem_ack at t+1+k -> rd_ack at t+2+k; 4 cycles min between grants.
// Backpressure: readers hold rd_req until rd_ack; downloader stalls on dl_wait, a lane-3 byte during dl_wait is dropped and flags dl_overrun.
// Ports: clk, reset_n (async active-low); rd_req/rd_addr/rd_ack/rd_data read side;
//   dl_wr/dl_addr/dl_data/dl_wait/dl_overrun download side; mem_req/mem_we/mem_addr/mem_wdata/mem_ack/mem_rdata memory side.
// Config: ROM_ARB_FIXED_PRIO_EN gives requester 0 fixed priority over the round-robin of the others.
module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 17
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        rd_req,
  input  logic [NUM_REQ*ADDR_W-1:0] rd_addr,
  output logic [NUM_REQ-1:0]        rd_ack,
  output logic [ROM_WORD_W-1:0]     rd_data,
  input  logic                      dl_wr,
  input  logic [ADDR_W+1:0]         dl_addr,
  input  logic [7:0]                dl_data,
  output logic                      dl_wait,
  output logic                      dl_overrun,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [ROM_WORD_W-1:0]     mem_wdata,
  input  logic                      mem_ack,
  input  logic [ROM_WORD_W-1:0]     mem_rdata
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e            state_q, state_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [NUM_REQ-1:0]    rd_ack_q, rd_ack_d;
  logic [ROM_WORD_W-1:0] rd_data_q, rd_data_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [ROM_WORD_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [2:0][7:0]       pack_q, pack_d;
  logic [ROM_WORD_W-1:0] wr_word_q, wr_word_d;
  logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
  logic                  wr_pending_q, wr_pending_d;
  logic                  overrun_q, overrun_d;

  logic [NUM_REQ-1:0]    pick_gnt;
  logic [PTR_W-1:0]      pick_idx;
  logic                  pick_vld;

  rom_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req     (rd_req),
    .ptr     (ptr_q),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .vld     (pick_vld)
  );

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gnt_d        = gnt_q;
    rd_ack_d     = '0;
    rd_data_d    = rd_data_q;
    mem_req_d    = 1'b0;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    pack_d       = pack_q;
    wr_word_d    = wr_word_q;
    wr_addr_d    = wr_addr_q;
    wr_pending_d = wr_pending_q;
    overrun_d    = overrun_q;

    // mem_ack is only meaningful in READ/WRITE; in IDLE/ACK it falls through unused.
    unique case (state_q)
      IDLE: begin
        if (wr_pending_q) begin
          state_d     = WRITE;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = wr_addr_q;
          mem_wdata_d = wr_word_q;
        end else if (pick_vld) begin
          state_d    = READ;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = rd_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
          gnt_d      = pick_gnt;
`ifdef ROM_ARB_FIXED_PRIO_EN
          // Grants to the priority requester leave the rotation of the others untouched.
          if (!pick_gnt[0]) ptr_d = pick_idx;
`else
          ptr_d = pick_idx;
`endif
        end
      end
      READ: begin
        if (mem_ack) begin
          rd_data_d = mem_rdata;
          rd_ack_d  = gnt_q;
          state_d   = ACK;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      WRITE: begin
        if (mem_ack) begin
          wr_pending_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Download packing. Commit needs wr_pending_q low, so it never collides with the WRITE clear above.
    if (dl_wr) begin
      if (dl_addr[1:0] == LANE_LAST) begin
        if (!wr_pending_q) begin
          wr_word_d    = {dl_data, pack_q};
          wr_addr_d    = dl_addr[ADDR_W+1:2];
          wr_pending_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else begin
        pack_d[dl_addr[1:0]] = dl_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      ptr_q        <= PTR_W'(NUM_REQ - 1);
      gnt_q        <= '0;
      rd_ack_q     <= '0;
      rd_data_q    <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      pack_q       <= '0;
      wr_word_q    <= '0;
      wr_addr_q    <= '0;
      wr_pending_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gnt_q        <= gnt_d;
      rd_ack_q     <= rd_ack_d;
      rd_data_q    <= rd_data_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      pack_q       <= pack_d;
      wr_word_q    <= wr_word_d;
      wr_addr_q    <= wr_addr_d;
      wr_pending_q <= wr_pending_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rd_ack     = rd_ack_q;
  assign rd_data    = rd_data_q;
  assign dl_wait    = wr_pending_q;
  assign dl_overrun = overrun_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter: self-checking bench for rom_port_arbiter with a behavioural memory responder.
// Latency: n/a.
// Backpressure: n/a.
module tb_rom_port_arbiter;

  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 17;

  logic                      clk = 1'b0;
  logic                      reset_n = 1'b0;
  logic [NUM_REQ-1:0]        rd_req = '0;
  logic [NUM_REQ*ADDR_W-1:0] rd_addr = '0;
  logic [NUM_REQ-1:0]        rd_ack;
  logic [31:0]               rd_data;
  logic                      dl_wr = 1'b0;
  logic [ADDR_W+1:0]         dl_addr = '0;
  logic [7:0]                dl_data = '0;
  logic                      dl_wait;
  logic                      dl_overrun;
  logic                      mem_req;
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [31:0]               mem_wdata;
  logic                      mem_ack;
  logic [31:0]               mem_rdata;

  int checks = 0;
  int failures = 0;

  rom_port_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_ack     (rd_ack),
    .rd_data    (rd_data),
    .dl_wr      (dl_wr),
    .dl_addr    (dl_addr),
    .dl_data    (dl_data),
    .dl_wait    (dl_wait),
    .dl_overrun (dl_overrun),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory responder: logs every issued op, acks auto ops after mem_k cycles (0 = random 1..3).
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
  } mem_op_t;

  mem_op_t     mem_log[$];
  int          mem_k = 1;
  bit          mem_auto = 1'b1;
  bit          mem_use_fixed = 1'b0;
  logic [31:0] mem_fixed = '0;
  int          manual_ack_req = 0;
  int          manual_ack_done = 0;

  initial begin : mem_model
    int cnt;
    bit busy;
    cnt = 0;
    busy = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (!reset_n) begin
        busy = 1'b0;
      end else if (mem_req) begin
        mem_log.push_back('{mem_we, mem_addr, mem_wdata});
        if (mem_auto) begin
          busy = 1'b1;
          cnt = (mem_k == 0) ? int'($urandom_range(1, 3)) : mem_k;
        end
      end else if (busy) begin
        cnt--;
        if (cnt == 0) begin
          busy = 1'b0;
          mem_ack = 1'b1;
          mem_rdata = mem_use_fixed ? mem_fixed : $urandom;
        end
      end
      if (manual_ack_req != manual_ack_done) begin
        manual_ack_done++;
        mem_ack = 1'b1;
        mem_rdata = mem_fixed;
      end
    end
  end

  // Sample/drive point: 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    mem_auto = 1'b1;
    mem_use_fixed = 1'b0;
    mem_k = 1;
    rd_req = '0;
    rd_addr = '0;
    dl_wr = 1'b0;
    dl_addr = '0;
    dl_data = '0;
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    rd_req = 3'b111;
    dl_wr = 1'b1;
    dl_addr = 19'h3;
    repeat (3) tick();
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== '0) begin
      failures++;
      $display("FAIL reset_mem_bus: got req=%b we=%b addr=%h wdata=%h want all 0", mem_req, mem_we, mem_addr, mem_wdata);
    end
    checks++;
    if ({rd_ack, rd_data} !== '0) begin
      failures++;
      $display("FAIL reset_read_side: got ack=%b data=%h want 0", rd_ack, rd_data);
    end
    checks++;
    if ({dl_wait, dl_overrun} !== 2'b00) begin
      failures++;
      $display("FAIL reset_dl_side: got wait=%b overrun=%b want 0", dl_wait, dl_overrun);
    end
    do_reset();
  endtask

  task automatic test_single_read();
    int lat, nreq;
    bit got;
    do_reset();
    mem_k = 2;
    mem_use_fixed = 1'b1;
    mem_fixed = 32'hDEADBEEF;
    rd_addr[1*ADDR_W +: ADDR_W] = 17'h00123;
    rd_req = 3'b010;
    lat = 0; nreq = 0; got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      lat++;
      if (mem_req) begin
        nreq++;
        checks++;
        if (mem_addr !== 17'h00123 || mem_we !== 1'b0) begin
          failures++;
          $display("FAIL single_issue: got addr=%h we=%b want addr=00123 we=0", mem_addr, mem_we);
        end
      end
      if (rd_ack !== '0) got = 1'b1;
    end
    checks++;
    if (got !== 1'b1 || rd_ack !== 3'b010) begin
      failures++;
      $display("FAIL single_ack: got seen=%b ack=%b want seen=1 ack=010", got, rd_ack);
    end
    checks++;
    if (rd_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL single_data: got %h want deadbeef", rd_data);
    end
    checks++;
    if (lat !== 4 || nreq !== 1) begin
      failures++;
      $display("FAIL single_latency: got lat=%0d strobes=%0d want lat=4 strobes=1", lat, nreq);
    end
    rd_req = '0;
    tick();
    checks++;
    if (rd_ack !== '0) begin
      failures++;
      $display("FAIL single_ack_pulse: got %b want 000", rd_ack);
    end
  endtask

  task automatic test_round_robin();
    int seq[$];
    int ack_cyc[$];
    int hold[NUM_REQ];
    int exp_seq[6];
`ifdef ROM_ARB_FIXED_PRIO_EN
    exp_seq = '{0, 1, 0, 2, 0, 1};
`else
    exp_seq = '{0, 1, 2, 0, 1, 2};
`endif
    do_reset();
    mem_k = 1;
    for (int i = 0; i < NUM_REQ; i++) begin
      hold[i] = 0;
      rd_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(32'h100 + i);
    end
    rd_req = 3'b111;
    for (int cyc = 0; cyc < 200 && seq.size() < 6; cyc++) begin
      tick();
      for (int i = 0; i < NUM_REQ; i++) begin
        if (hold[i] > 0) begin
          hold[i]--;
          if (hold[i] == 0) rd_req[i] = 1'b1;
        end
      end
      // A requester that was just acked stays low through the following IDLE cycle.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rd_ack[i]) begin
          seq.push_back(i);
          ack_cyc.push_back(cyc);
          rd_req[i] = 1'b0;
          hold[i] = 2;
        end
      end
    end
    rd_req = '0;
    checks++;
    if (seq.size() !== 6) begin
      failures++;
      $display("FAIL rr_count: got %0d acks want 6", seq.size());
    end
    for (int i = 0; i < seq.size(); i++) begin
      checks++;
      if (seq[i] !== exp_seq[i]) begin
        failures++;
        $display("FAIL rr_order[%0d]: got requester %0d want %0d", i, seq[i], exp_seq[i]);
      end
      if (i > 0) begin
        checks++;
        if (ack_cyc[i] - ack_cyc[i-1] !== 4) begin
          failures++;
          $display("FAIL rr_spacing[%0d]: got %0d cycles want 4", i, ack_cyc[i] - ack_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic send_byte(input logic [ADDR_W+1:0] a, input logic [7:0] d);
    dl_wr = 1'b1;
    dl_addr = a;
    dl_data = d;
    tick();
    dl_wr = 1'b0;
  endtask

  task automatic test_download();
    bit seen;
    int base;
    do_reset();
    mem_k = 2;
    base = mem_log.size();
    send_byte(19'h40, 8'h11);
    send_byte(19'h41, 8'h22);
    send_byte(19'h42, 8'h33);
    checks++;
    if (dl_wait !== 1'b0) begin
      failures++;
      $display("FAIL dl_wait_early: got %b want 0", dl_wait);
    end
    send_byte(19'h43, 8'h44);
    checks++;
    if (dl_wait !== 1'b1) begin
      failures++;
      $display("FAIL dl_wait_commit: got %b want 1", dl_wait);
    end
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      seen = mem_req;
    end
    checks++;
    if (seen !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 17'h10 || mem_wdata !== 32'h44332211) begin
      failures++;
      $display("FAIL dl_write_issue: got seen=%b we=%b addr=%h wdata=%h want 1 1 00010 44332211", seen, mem_we, mem_addr, mem_wdata);
    end
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      seen = mem_ack;
    end
    checks++;
    if (seen !== 1'b1 || dl_wait !== 1'b1 || mem_addr !== 17'h10 || mem_wdata !== 32'h44332211) begin
      failures++;
      $display("FAIL dl_wait_hold: got ackseen=%b wait=%b addr=%h wdata=%h want 1 1 00010 44332211", seen, dl_wait, mem_addr, mem_wdata);
    end
    tick();
    checks++;
    if (dl_wait !== 1'b0 || mem_log.size() - base !== 1) begin
      failures++;
      $display("FAIL dl_wait_release: got wait=%b ops=%0d want 0 1", dl_wait, mem_log.size() - base);
    end
  endtask

  task automatic test_overrun();
    int base, nwr;
    do_reset();
    mem_k = 8;
    base = mem_log.size();
    send_byte(19'h40, 8'h11);
    send_byte(19'h41, 8'h22);
    send_byte(19'h42, 8'h33);
    send_byte(19'h43, 8'h44);
    checks++;
    if (dl_overrun !== 1'b0 || dl_wait !== 1'b1) begin
      failures++;
      $display("FAIL ovr_first_word: got overrun=%b wait=%b want 0 1", dl_overrun, dl_wait);
    end
    send_byte(19'h44, 8'h55);
    send_byte(19'h45, 8'h66);
    send_byte(19'h46, 8'h77);
    send_byte(19'h47, 8'h88);
    checks++;
    if (dl_overrun !== 1'b1) begin
      failures++;
      $display("FAIL ovr_flag: got %b want 1", dl_overrun);
    end
    repeat (20) tick();
    nwr = 0;
    for (int i = base; i < mem_log.size(); i++) if (mem_log[i].we) nwr++;
    checks++;
    if (nwr !== 1) begin
      failures++;
      $display("FAIL ovr_write_count: got %0d writes want 1", nwr);
    end else begin
      checks++;
      if (mem_log[base].addr !== 17'h10 || mem_log[base].wdata !== 32'h44332211) begin
        failures++;
        $display("FAIL ovr_write_word: got addr=%h wdata=%h want 00010 44332211", mem_log[base].addr, mem_log[base].wdata);
      end
    end
    checks++;
    if (dl_overrun !== 1'b1 || dl_wait !== 1'b0) begin
      failures++;
      $display("FAIL ovr_sticky: got overrun=%b wait=%b want 1 0", dl_overrun, dl_wait);
    end
  endtask

  task automatic test_simultaneous();
    int base, ops_at_ack;
    bit acked;
    do_reset();
    mem_k = 2;
    base = mem_log.size();
    send_byte(19'h80, 8'hA1);
    send_byte(19'h81, 8'hB2);
    send_byte(19'h82, 8'hC3);
    rd_addr[2*ADDR_W +: ADDR_W] = 17'h0ABCD;
    rd_req = 3'b100;
    send_byte(19'h83, 8'hD4);
    acked = 1'b0;
    ops_at_ack = -1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (rd_ack[2] && !acked) begin
        acked = 1'b1;
        ops_at_ack = mem_log.size() - base;
        rd_req = '0;
      end
    end
    checks++;
    if (acked !== 1'b1 || ops_at_ack !== 1) begin
      failures++;
      $display("FAIL simul_read_first: got acked=%b ops_before_ack=%0d want 1 1", acked, ops_at_ack);
    end
    checks++;
    if (mem_log.size() - base !== 2) begin
      failures++;
      $display("FAIL simul_op_count: got %0d want 2", mem_log.size() - base);
    end else begin
      checks++;
      if (mem_log[base].we !== 1'b0 || mem_log[base].addr !== 17'h0ABCD) begin
        failures++;
        $display("FAIL simul_op0: got we=%b addr=%h want 0 0abcd", mem_log[base].we, mem_log[base].addr);
      end
      checks++;
      if (mem_log[base+1].we !== 1'b1 || mem_log[base+1].addr !== 17'h20 || mem_log[base+1].wdata !== 32'hD4C3B2A1) begin
        failures++;
        $display("FAIL simul_op1: got we=%b addr=%h wdata=%h want 1 00020 d4c3b2a1", mem_log[base+1].we, mem_log[base+1].addr, mem_log[base+1].wdata);
      end
    end
  endtask

  task automatic test_reset_midop();
    bit seen;
    do_reset();
    mem_k = 1;
    mem_use_fixed = 1'b1;
    mem_fixed = 32'h12345678;
    rd_addr[0*ADDR_W +: ADDR_W] = 17'h00777;
    rd_req = 3'b001;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      seen = rd_ack[0];
    end
    rd_req = '0;
    checks++;
    if (seen !== 1'b1 || rd_data !== 32'h12345678) begin
      failures++;
      $display("FAIL midrst_setup: got acked=%b data=%h want 1 12345678", seen, rd_data);
    end
    tick();
    mem_auto = 1'b0;
    rd_addr[1*ADDR_W +: ADDR_W] = 17'h1F0F0;
    rd_req = 3'b010;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      seen = mem_req;
    end
    // Reset lands between clock edges while READ awaits its ack.
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (seen !== 1'b1 || {mem_req, mem_we, mem_addr, mem_wdata} !== '0) begin
      failures++;
      $display("FAIL midrst_mem_async: got seen=%b req=%b we=%b addr=%h wdata=%h want 1 then all 0", seen, mem_req, mem_we, mem_addr, mem_wdata);
    end
    checks++;
    if ({rd_ack, rd_data, dl_wait, dl_overrun} !== '0) begin
      failures++;
      $display("FAIL midrst_rd_async: got ack=%b data=%h wait=%b ovr=%b want 0", rd_ack, rd_data, dl_wait, dl_overrun);
    end
    rd_req = '0;
    #1;
    reset_n = 1'b1;
    tick();
    manual_ack_req++;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (rd_ack !== '0 || mem_req !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL midrst_stray_ack: got activity=%b want 0", seen);
    end
    mem_auto = 1'b1;
    rd_addr[0*ADDR_W +: ADDR_W] = 17'h00AAA;
    rd_addr[1*ADDR_W +: ADDR_W] = 17'h00BBB;
    rd_addr[2*ADDR_W +: ADDR_W] = 17'h00CCC;
    rd_req = 3'b111;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      seen = mem_req;
    end
    checks++;
    if (seen !== 1'b1 || mem_addr !== 17'h00AAA) begin
      failures++;
      $display("FAIL midrst_first_grant: got seen=%b addr=%h want 1 00aaa", seen, mem_addr);
    end
    rd_req = '0;
  endtask

  // Random readers against a transaction model: one read at a time, each granted to the first
  // requester after the last winner, acked one cycle after the memory completes.
  task automatic test_random_reads();
    int mptr, cur_g, phase, nacks;
    bit ack_prev, exp_req_now;
    logic [31:0] data_prev, exp_data;
    logic [NUM_REQ-1:0] exp_ack_now;
    bit req_bad, ack_bad, data_bad;
    do_reset();
    mem_k = 0;
    mptr = NUM_REQ - 1;
    cur_g = 0;
    phase = 0;          // 0 idle, 1 read outstanding, 2 ack cycle (state of the cycle just ended)
    nacks = 0;
    ack_prev = 1'b0;
    data_prev = '0;
    exp_data = '0;
    req_bad = 1'b0; ack_bad = 1'b0; data_bad = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      tick();
      exp_req_now = 1'b0;
      exp_ack_now = '0;
      if (phase == 0) begin
        if (rd_req != '0) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
          if (rd_req[0]) begin
            cur_g = 0;
          end else begin
            for (int o = 1; o <= NUM_REQ; o++) begin
              if (rd_req[(mptr + o) % NUM_REQ]) begin cur_g = (mptr + o) % NUM_REQ; break; end
            end
            mptr = cur_g;
          end
`else
          for (int o = 1; o <= NUM_REQ; o++) begin
            if (rd_req[(mptr + o) % NUM_REQ]) begin cur_g = (mptr + o) % NUM_REQ; break; end
          end
          mptr = cur_g;
`endif
          exp_req_now = 1'b1;
          phase = 1;
        end
      end else if (phase == 1) begin
        if (ack_prev) begin
          exp_ack_now[cur_g] = 1'b1;
          exp_data = data_prev;
          phase = 2;
          nacks++;
        end
      end else begin
        phase = 0;
      end
      checks++;
      if (mem_req !== exp_req_now || (exp_req_now && (mem_we !== 1'b0 || mem_addr !== rd_addr[cur_g*ADDR_W +: ADDR_W]))) begin
        failures++;
        if (!req_bad) $display("FAIL rand_issue@%0d: got req=%b we=%b addr=%h want req=%b addr=%h", cyc, mem_req, mem_we, mem_addr, exp_req_now, rd_addr[cur_g*ADDR_W +: ADDR_W]);
        req_bad = 1'b1;
      end
      checks++;
      if (rd_ack !== exp_ack_now) begin
        failures++;
        if (!ack_bad) $display("FAIL rand_ack@%0d: got %b want %b", cyc, rd_ack, exp_ack_now);
        ack_bad = 1'b1;
      end
      checks++;
      if (rd_data !== exp_data) begin
        failures++;
        if (!data_bad) $display("FAIL rand_data@%0d: got %h want %h", cyc, rd_data, exp_data);
        data_bad = 1'b1;
      end
      ack_prev = mem_ack;
      data_prev = mem_rdata;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (exp_ack_now[i]) begin
          rd_req[i] = 1'b0;
        end else if (!rd_req[i] && $urandom_range(0, 3) == 0) begin
          rd_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
          rd_req[i] = 1'b1;
        end
      end
    end
    rd_req = '0;
    checks++;
    if (nacks < 50) begin
      failures++;
      $display("FAIL rand_progress: got %0d completed reads want at least 50", nacks);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_download();
    test_overrun();
    test_simultaneous();
    test_reset_midop();
    test_random_reads();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
